// File: rtl/lisa_uart_rx_fifo.sv
// 8N1 UART receiver with 8x oversampled majority voting and a show-ahead receive FIFO.
// Sticky framing/overrun flags; a single rising-edge clock domain with synchronous reset.
module lisa_uart_rx_fifo #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_ref,
    input  logic       rxd,
    input  logic       rd,
    input  logic       clr_err,
    output logic [7:0] d,
    output logic       data_avail,
    output logic       fifo_full,
    output logic       frame_err,
    output logic       overrun
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } rx_state_t;

    // ------------------------------------------------------------------
    // rxd synchronizer, reset to the idle (mark) level
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every
            // stage samples the value from before this edge.
            sync_q[0] <= rxd;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    rx_state_t  state_q, state_d;
    logic [2:0] tcnt_q, tcnt_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [1:0] samp_q, samp_d;
    logic       vote;
    logic       push;
    logic       frame_set;

    // Majority of the samples at tcnt 3 and 4 plus the live sample at tcnt 5.
    assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tcnt_q  <= 3'd0;
            bcnt_q  <= 3'd0;
            shreg_q <= 8'h00;
            samp_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
            samp_q  <= samp_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can infer a latch.
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        bcnt_d    = bcnt_q;
        shreg_d   = shreg_q;
        samp_d    = samp_q;
        push      = 1'b0;
        frame_set = 1'b0;

        if (baud_ref) begin
            if (tcnt_q == 3'd3) samp_d[0] = rxs;
            if (tcnt_q == 3'd4) samp_d[1] = rxs;

            case (state_q)
                S_IDLE: begin
                    if (!rxs) begin
                        state_d = S_START;
                        tcnt_d  = 3'd1;
                    end
                end

                S_START: begin
                    tcnt_d = tcnt_q + 3'd1;
                    if (tcnt_q == 3'd5 && vote) begin
                        state_d = S_IDLE;
                        tcnt_d  = 3'd0;
                    end else if (tcnt_q == 3'd7) begin
                        state_d = S_DATA;
                        tcnt_d  = 3'd0;
                        bcnt_d  = 3'd0;
                    end
                end

                S_DATA: begin
                    tcnt_d = tcnt_q + 3'd1;
                    if (tcnt_q == 3'd5) begin
                        shreg_d = {vote, shreg_q[7:1]};
                    end
                    if (tcnt_q == 3'd7) begin
                        if (bcnt_q == 3'd7) begin
                            state_d = S_STOP;
                        end else begin
                            bcnt_d = bcnt_q + 3'd1;
                        end
                    end
                end

                S_STOP: begin
                    tcnt_d = tcnt_q + 3'd1;
                    // Leave half a bit early so a slightly fast sender cannot
                    // have its next start edge missed.
                    if (tcnt_q == 3'd5) begin
                        tcnt_d = 3'd0;
                        if (vote) begin
                            push    = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            frame_set = 1'b1;
                            state_d   = S_BREAK;
                        end
                    end
                end

                S_BREAK: begin
                    if (rxs) begin
                        state_d = S_IDLE;
                        tcnt_d  = 3'd0;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    tcnt_d  = 3'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          ovr_set;

    assign full    = (count == FULL_CNT);
    assign do_pop  = rd && (count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign ovr_set = push && full && !do_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; the count gates
    // every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shreg_q;
    end

    assign data_avail = (count != '0);
    assign fifo_full  = full;
    assign d          = data_avail ? mem[rd_ptr] : 8'h00;

    // ------------------------------------------------------------------
    // Sticky error flags; a set event beats a clear in the same cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_set)    frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;

            if (ovr_set)      overrun <= 1'b1;
            else if (clr_err) overrun <= 1'b0;
        end
    end

endmodule
